// File: rtl/shift_arbiter_pkg.sv
// ============================================================================
//  Module   : shift_arbiter_pkg
//  Brief    : Shared encodings for the shift arbiter (op codes, requester IDs,
//             FSM state codes, datapath widths).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_arbiter_pkg;

    localparam int DATA_W  = 16;
    localparam int SHAMT_W = 4;

    // Operation encodings
    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    // Requester identifiers as reported on res_id
    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    // Result-register state machine
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

endpackage : shift_arbiter_pkg

`default_nettype wire

// File: rtl/shift_unit.sv
// ============================================================================
//  Module   : shift_unit
//  Brief    : Combinational 16-bit shifter: logical left, logical right,
//             arithmetic right and pass-through, selected by a 2-bit op.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_unit
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         op_i,
    output logic [DATA_W-1:0]  result_o
);

    logic [DATA_W-1:0] w_sll;
    logic [DATA_W-1:0] w_srl;
    logic [DATA_W-1:0] w_sra;

    // The three shifters; a zero shift amount naturally returns the operand
    assign w_sll = data_i << shamt_i;
    assign w_srl = data_i >> shamt_i;
    assign w_sra = $unsigned($signed(data_i) >>> shamt_i);

    // 4:1 op select
    always_comb begin
        result_o = data_i;
        case (op_i)
            OP_SLL:  result_o = w_sll;
            OP_SRL:  result_o = w_srl;
            OP_SRA:  result_o = w_sra;
            default: result_o = data_i;
        endcase
    end

endmodule : shift_unit

`default_nettype wire

// File: rtl/shift_arbiter.sv
// ============================================================================
//  Module   : shift_arbiter
//  Brief    : Two requesters (A, B) share one shift unit through a single
//             result register. Round-robin arbitration by default; defining
//             SHIFT_ARB_FIXED_PRIO_EN gives A fixed priority and removes the
//             round-robin pointer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_arbiter
    import shift_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,

    input  logic               a_valid,
    output logic               a_ready,
    input  logic [1:0]         a_op,
    input  logic [DATA_W-1:0]  a_data,
    input  logic [SHAMT_W-1:0] a_shamt,

    input  logic               b_valid,
    output logic               b_ready,
    input  logic [1:0]         b_op,
    input  logic [DATA_W-1:0]  b_data,
    input  logic [SHAMT_W-1:0] b_shamt,

    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_data,
    output logic               res_id
);

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [DATA_W-1:0] res_data_q;
    logic              res_id_q;

    logic              w_slot;
    logic              w_grant_b;
    logic              w_accept;
    logic [1:0]        w_op;
    logic [DATA_W-1:0] w_data;
    logic [SHAMT_W-1:0] w_shamt;
    logic [DATA_W-1:0] w_shift;

    // An accept slot exists when empty, or when full and being drained now
    assign w_slot   = !rst && ((state_q == ST_IDLE) || res_ready);
    assign w_accept = a_ready || b_ready;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    // B only wins when A is not asking
    assign w_grant_b = b_valid && !a_valid;
`else
    logic prio_b_q;  // 1: B is favoured on the next contended cycle

    // B wins when alone, or when contended and A was granted last
    assign w_grant_b = b_valid && (!a_valid || prio_b_q);

    // Pointer moves only on a real accept, towards the requester not granted
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_b_q <= 1'b0;
        end else if (w_accept) begin
            prio_b_q <= a_ready;
        end
    end
`endif

    // Winner's operands steer the single shared shifter
    assign w_op    = w_grant_b ? b_op    : a_op;
    assign w_data  = w_grant_b ? b_data  : a_data;
    assign w_shamt = w_grant_b ? b_shamt : a_shamt;

    shift_unit u_shift_unit (
        .data_i   (w_data),
        .shamt_i  (w_shamt),
        .op_i     (w_op),
        .result_o (w_shift)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: any accept (fresh or back-to-back) leaves us FULL
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_accept) state_d = ST_FULL;
            ST_FULL: if (res_ready) state_d = w_accept ? ST_FULL : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: handshake outputs from state, valids and the grant
    always_comb begin
        res_valid = (state_q == ST_FULL);
        a_ready   = w_slot && a_valid && !w_grant_b;
        b_ready   = w_slot && w_grant_b;
    end

    // Result register loads only on accept, so it holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_q <= '0;
            res_id_q   <= ID_A;
        end else if (w_accept) begin
            res_data_q <= w_shift;
            res_id_q   <= w_grant_b ? ID_B : ID_A;
        end
    end

    assign res_data = res_data_q;
    assign res_id   = res_id_q;

endmodule : shift_arbiter

`default_nettype wire
